// File: rtl/button_event_gen.sv
// Turns debounced button levels into queued PRESS/RELEASE/LONG/REPEAT events.
// Per-button FSMs feed pending slots, a fixed-priority arbiter and a FWFT FIFO.
module button_event_gen #(
    parameter int WIDTH         = 8,
    parameter int IDX_WIDTH     = 3,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_WIDTH     = 26,
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 event_ready,
    input  logic                 clear_overflow,
    output logic                 event_valid,
    output logic [1:0]           event_code,
    output logic [IDX_WIDTH-1:0] event_index,
    output logic [WIDTH-1:0]     level_out,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_e;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    localparam int EW = IDX_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [FIFO_AW:0]     DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_e               state_q [WIDTH];
    state_e               state_d [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0]     gen;
    logic [1:0]           gen_code [WIDTH];

    logic [WIDTH-1:0]     pend_v_q;
    logic [WIDTH-1:0]     pend_v_d;
    logic [1:0]           pend_c_q [WIDTH];
    logic [1:0]           pend_c_d [WIDTH];

    logic [WIDTH-1:0]     grant;
    logic                 sel_valid;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic [1:0]           sel_code;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wptr_q, wptr_d;
    logic [FIFO_AW-1:0]   rptr_q, rptr_d;
    logic [FIFO_AW:0]     count_q, count_d;

    logic [WIDTH-1:0]     level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 lost;
    logic                 push, pop, push_ok;

    // Per-button event detection; a release beats a same-cycle terminal count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gen      = '0;
        gen_code = '{default: EV_PRESS};
        for (int i = 0; i < WIDTH; i++) begin
            unique case (state_q[i])
                ST_IDLE: begin
                    if (data_in[i]) begin
                        gen[i]      = 1'b1;
                        gen_code[i] = EV_PRESS;
                        state_d[i]  = ST_PRESSED;
                        cnt_d[i]    = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!data_in[i]) begin
                        gen[i]      = 1'b1;
                        gen_code[i] = EV_RELEASE;
                        state_d[i]  = ST_IDLE;
                        cnt_d[i]    = '0;
                    end else if (cnt_q[i] == LONG_TC) begin
                        gen[i]      = 1'b1;
                        gen_code[i] = EV_LONG;
                        state_d[i]  = ST_HELD;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
                ST_HELD: begin
                    if (!data_in[i]) begin
                        gen[i]      = 1'b1;
                        gen_code[i] = EV_RELEASE;
                        state_d[i]  = ST_IDLE;
                        cnt_d[i]    = '0;
                    end else if (cnt_q[i] == REPEAT_TC) begin
                        gen[i]      = 1'b1;
                        gen_code[i] = EV_REPEAT;
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Lowest index wins: scanning downward lets the last hit stick.
    always_comb begin
        grant     = '0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_code  = EV_PRESS;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_v_q[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                sel_valid = 1'b1;
                sel_idx   = IDX_WIDTH'(i);
                sel_code  = pend_c_q[i];
            end
        end
    end

    assign event_valid = (count_q != '0);
    assign pop         = event_valid & event_ready;
    assign push_ok     = (count_q < DEPTH_C) | pop;
    assign push        = sel_valid & push_ok;

    always_comb begin
        pend_v_d = '0;
        pend_c_d = pend_c_q;
        lost     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_v_d[i] = gen[i] | (pend_v_q[i] & ~(push & grant[i]));
            if (gen[i]) begin
                pend_c_d[i] = gen_code[i];
                if (pend_v_q[i] && !(push && grant[i])) begin
                    lost = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wptr_q] = {sel_code, sel_idx};
            wptr_d        = wptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + FIFO_AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Set beats clear so an event lost during the clear is still reported.
    always_comb begin
        level_d = data_in;
        ovf_d   = (ovf_q & ~clear_overflow) | lost;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i]  <= ST_IDLE;
                cnt_q[i]    <= '0;
                pend_c_q[i] <= EV_PRESS;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            pend_v_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_c_q <= pend_c_d;
            mem_q    <= mem_d;
            pend_v_q <= pend_v_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign {event_code, event_index} = mem_q[rptr_q];
    assign level_out                 = level_q;
    assign overflow                  = ovf_q;

endmodule
